mont_mult: RTL and testbench
============================

Name: mont_mult

Overview:
- Radix-2 bit-serial Montgomery modular multiplier. Computes P = A·B·2^-W mod N.
- Sits directly downstream of the RSA pre-processing stage. It consumes the pre-processed value V (M·2^W mod N) as an operand and provides the multiply primitive that the exponentiation controller sequences.
- One multiplication per start; result is held until the next start.

Parameters:
W, 256, operand/modulus width in bits (benches may use 8 for hand-checkable vectors)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle request; sampled only in IDLE
A  input  W  multiplier operand, scanned LSB first; requires A < N
B  input  W  multiplicand operand; requires B < N
N  input  W  modulus; must be odd, N > 1
P  output  W  Montgomery product, valid when ready pulses; held afterwards
ready  output  1  one-cycle completion pulse
busy  output  1  high in CALC and FINAL

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, P = 0, ready = 0, busy = 0, counter = 0, accumulator R = 0.
  - Reset during CALC or FINAL aborts the operation. No ready is produced for it.
- States: IDLE, CALC, FINAL.
- IDLE:
  - If start = 1 at an edge: latch A, B, N into internal registers, set R = 0 and counter = 0, go to CALC.
  - Otherwise stay in IDLE.
  - A, B and N may change after the start edge without affecting the result.
- CALC: one iteration per edge, counter runs 0..W-1. Per iteration with a = A_reg[counter]:
  - T = R + (a ? B_reg : 0)
  - T = T + (T[0] ? N_reg : 0)
  - R = T >> 1
  - Then increment the counter.
  - On the iteration with counter = W-1, go to FINAL.
- Width rule: R and T are W+2 bits. The invariant R < 2N holds, so T < 4N < 2^(W+2) and no overflow occurs. The shift is logical.
- FINAL (one edge):
  - P = (R >= N_reg) ? R - N_reg : R, truncated to W bits.
  - ready = 1, go to IDLE.
- ready:
  - High for exactly one cycle, the cycle following the FINAL edge.
  - Cleared on the next edge.
- Latency:
  - Start sampled at edge e0. Iterations occur at e1..eW, FINAL at e(W+1).
  - ready is high between e(W+1) and e(W+2). That is W+1 edges from start to ready, i.e. 257 for W=256.
- start while busy (CALC/FINAL) is ignored. It is not queued and has no effect on the running operation.
- start asserted in the cycle ready is high: state is already IDLE, so the new operation is accepted. P keeps the old result until the new FINAL edge.
- P changes only at a FINAL edge or on reset.
- Output guarantee: P < N whenever the input preconditions hold. Behaviour for even N or operands ≥ N is unspecified; it must not hang, and the latency is unchanged.
- Fully synchronous datapath apart from rst_n. No combinational path from inputs to outputs.

Test Plan:
- W=8, N=13, A=5, B=7, start one cycle -> ready pulses exactly 9 edges after the start edge, P=1 (35·3 mod 13, since 2^-8 ≡ 3). busy is high for 9 cycles.
- W=8, N=255, A=254, B=254 -> P=1. This exercises the final subtraction path (2^8 ≡ 1 mod 255). Then A=0, B=200 -> P=0.
- W=256, N=2^256-1, A=B=N-1 -> P=1 after 257 edges. A=3, B=5 on the same N -> P=15.
- W=8, N=13: start A=5, B=7; pulse start again with A=1, B=1 at iteration 4 -> single ready at the original latency, P=1, no second ready. Then a start coincident with the ready cycle, A=1, B=3 -> accepted, P=9 after 9 more edges.
- W=8: deassert rst_n at iteration 5 -> P=0, ready=0, busy=0 immediately, without waiting for a clock edge. Release reset, issue a new start with N=13, A=5, B=7 -> P=1 with normal latency.
- Random regression, W=8 and W=256: odd N, A,B < N -> P·2^W mod N == A·B mod N; P < N; exactly one ready per accepted start.

Source files
------------

// File: rtl/mont_mult.sv
// Radix-2 bit-serial Montgomery multiplier: P = A*B*2^-W mod N.
// One iteration per cycle, then a single conditional subtraction.
module mont_mult #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] N,
    output logic [W-1:0] P,
    output logic         ready,
    output logic         busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
    logic [W+1:0]   r_q, r_d;
    logic           ready_q, ready_d;
    logic [W+1:0]   t_add, t_red, r_sub;

    // R stays below 2N, so W+2 bits hold the intermediate sum without overflow.
    always_comb begin
        t_add = r_q + (a_q[cnt_q] ? {2'b00, b_q} : '0);
        t_red = t_add + (t_add[0] ? {2'b00, n_q} : '0);
        r_sub = r_q - {2'b00, n_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        r_d     = r_q;
        p_d     = p_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    n_d     = N;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d   = t_red >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) state_d = FINAL;
            end
            FINAL: begin
                p_d     = (r_q >= {2'b00, n_q}) ? r_sub[W-1:0] : r_q[W-1:0];
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            r_q     <= '0;
            p_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            r_q     <= r_d;
            p_q     <= p_d;
            ready_q <= ready_d;
        end
    end

    assign P     = p_q;
    assign ready = ready_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mont_mult.sv
// Scoreboard bench for mont_mult at W=8 and W=256; expected products come
// from modular arithmetic using (N+1)/2 as the inverse of 2.
module tb_mont_mult;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st8 = 1'b0, st2 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0, n8 = '0;
    logic [255:0] a2 = '0, b2 = '0, n2 = '0;
    logic [7:0]   p8;
    logic [255:0] p2;
    logic         rdy8, bsy8, rdy2, bsy2;

    int tests = 0;
    int fails = 0;
    logic [255:0] exp8[$];
    logic [255:0] exp2[$];

    always #5 clk = ~clk;

    mont_mult #(.W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8), .N(n8),
        .P(p8), .ready(rdy8), .busy(bsy8)
    );
    mont_mult #(.W(256)) u256 (
        .clk(clk), .rst_n(rst_n), .start(st2), .A(a2), .B(b2), .N(n2),
        .P(p2), .ready(rdy2), .busy(bsy2)
    );

    // A*B*2^-w mod n, with 2^-1 = (n+1)/2 for odd n.
    function automatic logic [255:0] ref_mm(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] n, input int w);
        logic [511:0] nn, h, acc;
        nn  = {256'b0, n};
        h   = (nn + 512'd1) >> 1;
        acc = ({256'b0, a} * {256'b0, b}) % nn;
        for (int i = 0; i < w; i++) acc = (acc * h) % nn;
        return acc[255:0];
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [255:0] e;
        if (rdy8) begin
            if (exp8.size() == 0) check("spurious_ready8", 1, 0);
            else begin e = exp8.pop_front(); check("p8", {248'b0, p8}, e); end
        end
        if (rdy2) begin
            if (exp2.size() == 0) check("spurious_ready256", 1, 0);
            else begin e = exp2.pop_front(); check("p256", p2, e); end
        end
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Pulse start for one cycle, push the expectation, then scramble inputs.
    task automatic issue(input bit big, input logic [255:0] a, input logic [255:0] b,
                         input logic [255:0] n);
        @(negedge clk);
        if (big) begin
            st2 = 1'b1; a2 = a; b2 = b; n2 = n;
            exp2.push_back(ref_mm(a, b, n, 256));
        end else begin
            st8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; n8 = n[7:0];
            exp8.push_back(ref_mm({248'b0, a[7:0]}, {248'b0, b[7:0]}, {248'b0, n[7:0]}, 8));
        end
        @(negedge clk);
        st8 = 1'b0; st2 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); n8 = 8'($urandom);
        a2 = rnd256(); b2 = rnd256(); n2 = rnd256();
    endtask

    task automatic wait_ready(input bit big, output int cyc, output int bcnt);
        int lim;
        lim  = big ? 600 : 40;
        cyc  = 0;
        bcnt = (big ? bsy2 : bsy8) ? 1 : 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (big ? rdy2 : rdy8) break;
            if (big ? bsy2 : bsy8) bcnt++;
            if (cyc > lim) begin
                check("ready_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic run(input bit big, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] n);
        int cyc, bc, w;
        w = big ? 256 : 8;
        issue(big, a, b, n);
        wait_ready(big, cyc, bc);
        check("latency", cyc, w + 1);
        check("busy_cycles", bc, w + 1);
    endtask

    initial begin
        int cyc, bc;
        logic [255:0] a, b, n, nmax;

        repeat (3) @(negedge clk);
        check("rst_p8", {248'b0, p8}, 0);
        check("rst_ready8", {255'b0, rdy8}, 0);
        check("rst_busy8", {255'b0, bsy8}, 0);
        check("rst_p256", p2, 0);
        rst_n = 1'b1;

        run(0, 5, 7, 13);
        check("p8_hold", {248'b0, p8}, 1);
        run(0, 254, 254, 255);
        run(0, 0, 200, 255);

        // Start while busy is ignored; start in the ready cycle is accepted.
        issue(0, 5, 7, 13);
        repeat (4) @(negedge clk);
        st8 = 1'b1; a8 = 1; b8 = 1; n8 = 13;
        @(negedge clk);
        st8 = 1'b0;
        wait_ready(0, cyc, bc);
        check("latency_busy_start", cyc, 4);
        st8 = 1'b1; a8 = 1; b8 = 3; n8 = 13;
        exp8.push_back(ref_mm(1, 3, 13, 8));
        @(negedge clk);
        st8 = 1'b0;
        check("p8_old_held", {248'b0, p8}, 1);
        wait_ready(0, cyc, bc);
        check("latency_coincident", cyc, 9);

        // Asynchronous reset mid-operation aborts without a ready.
        issue(0, 5, 7, 13);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_p8", {248'b0, p8}, 0);
        check("abort_ready8", {255'b0, rdy8}, 0);
        check("abort_busy8", {255'b0, bsy8}, 0);
        void'(exp8.pop_back());
        void'(exp2.size());
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 5, 7, 13);

        for (int i = 0; i < 30; i++) begin
            n = 256'($urandom_range(1, 127) * 2 + 1);
            a = 256'($urandom_range(0, 32'(n) - 1));
            b = 256'($urandom_range(0, 32'(n) - 1));
            run(0, a, b, n);
        end

        nmax = '1;
        run(1, nmax - 1, nmax - 1, nmax);
        check("p256_one", p2, 1);
        run(1, 3, 5, nmax);
        check("p256_fifteen", p2, 15);
        for (int i = 0; i < 4; i++) begin
            n = rnd256() | 256'd1;
            if (n <= 1) n = 3;
            a = rnd256() % n;
            b = rnd256() % n;
            run(1, a, b, n);
        end

        repeat (3) @(negedge clk);
        check("pending8", exp8.size(), 0);
        check("pending256", exp2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
